// File: rtl/lift_pkg.sv
// Shared types and default sizes for the lift call dispatcher.
//   NUM_FLOORS   : default number of floors / call buttons
//   FLOOR_W      : floor index width
//   floor_t      : floor index
//   floor_mask_t : one bit per floor
//   disp_state_t : dispatcher FSM states
package lift_pkg;

    localparam int unsigned NUM_FLOORS = 8;
    localparam int unsigned FLOOR_W    = $clog2(NUM_FLOORS);

    typedef logic [FLOOR_W-1:0]    floor_t;
    typedef logic [NUM_FLOORS-1:0] floor_mask_t;

    typedef enum logic [1:0] {IDLE, SELECT, ISSUE, GAP} disp_state_t;

endpackage

// File: rtl/button_debounce.sv
// One-bit button front end: 2-flop synchronizer, debounce counter and
// registered rising-edge pulse of the debounced level.
//   clk     : clock
//   reset   : asynchronous active-low reset
//   btn_i   : raw asynchronous button level
//   press_o : one-cycle pulse per accepted press
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;

    // The counter tracks consecutive samples that disagree with the accepted
    // level; any agreeing sample restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
                press_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/lift_call_dispatcher.sv
// Lift call dispatcher: debounces floor buttons, latches calls into a
// pending bitmap and offers them one at a time in direction-aware order.
//   clk            : clock, rising edge
//   reset          : asynchronous active-low reset
//   btn            : raw button levels, bit f = floor f
//   current_floor  : lift position
//   door_open      : door open at current_floor (serves that floor)
//   dir_up         : travel direction, 1 = up
//   emergency_stop : freezes/aborts request issuing
//   req_floor      : offered floor, qualified by req_valid
//   req_valid      : req_floor is a live request
//   pending        : latched unserved calls
//   busy           : FSM not in IDLE
module lift_call_dispatcher #(
    parameter int unsigned NUM_FLOORS      = lift_pkg::NUM_FLOORS,
    parameter int unsigned FLOOR_W         = lift_pkg::FLOOR_W,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  door_open,
    input  logic                  dir_up,
    input  logic                  emergency_stop,
    output logic [FLOOR_W-1:0]    req_floor,
    output logic                  req_valid,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);

    import lift_pkg::*;

    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

    disp_state_t             state_q, state_d;
    logic [NUM_FLOORS-1:0]   press, served, cand, issue_set, issue_clr;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d, issued_q, issued_d;
    logic [FLOOR_W-1:0]      req_floor_q, req_floor_d;
    logic [HoldW-1:0]        hold_q, hold_d;
    logic                    req_valid_q, busy_q;
    logic [FLOOR_W:0]        sel;

    for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .btn_i  (btn[f]),
            .press_o(press[f])
        );
    end

    // Returns {found, floor}. Ascending scans keep the highest hit,
    // descending scans keep the lowest hit.
    function automatic logic [FLOOR_W:0] select_floor(input logic [NUM_FLOORS-1:0] c,
                                                      input logic [FLOOR_W-1:0] cur,
                                                      input logic up);
        logic               hit_near, hit_far;
        logic [FLOOR_W-1:0] near, far;
        hit_near = 1'b0;
        hit_far  = 1'b0;
        near     = '0;
        far      = '0;
        if (up) begin
            for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
                if (c[i] && i >= int'(cur)) begin hit_near = 1'b1; near = FLOOR_W'(i); end
            end
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (c[i] && i < int'(cur)) begin hit_far = 1'b1; far = FLOOR_W'(i); end
            end
        end else begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (c[i] && i <= int'(cur)) begin hit_near = 1'b1; near = FLOOR_W'(i); end
            end
            for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
                if (c[i] && i > int'(cur)) begin hit_far = 1'b1; far = FLOOR_W'(i); end
            end
        end
        return hit_near ? {1'b1, near} : {hit_far, far};
    endfunction

    always_comb begin
        served = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            served[f] = door_open && (current_floor == FLOOR_W'(f));
        end
    end

    assign cand = pending_q & ~issued_q;
    assign sel  = select_floor(cand, current_floor, dir_up);

    always_comb begin
        state_d     = state_q;
        req_floor_d = req_floor_q;
        hold_d      = hold_q;
        issue_set   = '0;
        issue_clr   = '0;
        unique case (state_q)
            IDLE: begin
                if ((|cand) && !emergency_stop) state_d = SELECT;
            end
            SELECT: begin
                if (emergency_stop) begin
                    state_d = IDLE;
                end else if (sel[FLOOR_W]) begin
                    req_floor_d              = sel[FLOOR_W-1:0];
                    issue_set[sel[FLOOR_W-1:0]] = 1'b1;
                    hold_d                   = '0;
                    state_d                  = ISSUE;
                end else begin
                    // Candidate was served between IDLE and SELECT.
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (emergency_stop) begin
                    issue_clr[req_floor_q] = 1'b1;
                    state_d                = IDLE;
                end else if (hold_q == HoldW'(HOLD_CYCLES - 1)) begin
                    state_d = GAP;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            GAP: begin
                if (emergency_stop) issue_clr[req_floor_q] = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Service clear dominates any set in the same cycle.
    assign pending_d = (pending_q | press) & ~served;
    assign issued_d  = (issued_q | issue_set) & ~issue_clr & ~served;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            issued_q    <= '0;
            req_floor_q <= '0;
            hold_q      <= '0;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            issued_q    <= issued_d;
            req_floor_q <= req_floor_d;
            hold_q      <= hold_d;
            req_valid_q <= (state_d == ISSUE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign req_floor = req_floor_q;
    assign req_valid = req_valid_q;
    assign pending   = pending_q;
    assign busy      = busy_q;

endmodule
